// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN datapath stages.
// sat_to_bits is only referenced when KERNEL_ACC_SATURATE_EN is defined.
package cnn_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} kacc_state_t;
  typedef logic signed [3:0] weight_t;

  function automatic int acc_width(input int bit_size, input int n);
    return bit_size + 4 + $clog2(n);
  endfunction

  // Clamp a sign-extended accumulator into the signed range of `bits` bits.
  function automatic logic signed [63:0] sat_to_bits(input logic signed [63:0] v, input int bits);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction
endpackage

// File: rtl/kernel_accumulator_if.sv
// Activation-in / window-sum-out handshake bundle for kernel_accumulator.
interface kernel_accumulator_if #(parameter int BitSize = 32);
  logic                      i_valid;
  logic signed [BitSize-1:0] i_data;
  logic                      o_ready;
  logic                      o_valid;
  logic signed [BitSize-1:0] o_data;
  logic                      i_ready;

  modport master (output i_valid, i_data, i_ready, input o_ready, o_valid, o_data);
  modport slave  (input i_valid, i_data, i_ready, output o_ready, o_valid, o_data);
endinterface

// File: rtl/kernel_weight_bank.sv
// Per-tap 4-bit signed kernel weight storage, loaded in bulk, read by tap index.
module kernel_weight_bank
  import cnn_pkg::*;
#(
  parameter int N    = 9,
  parameter int TapW = (N > 1) ? $clog2(N) : 1
)(
  input  logic            clk,
  input  logic            res_n,
  input  logic            load,
  input  logic [4*N-1:0]  weights,
  input  logic [TapW-1:0] tap,
  output weight_t         weight
);
  weight_t bank [N];

  for (genvar k = 0; k < N; k++) begin : g_tap
    always_ff @(posedge clk or negedge res_n)
      if (!res_n)    bank[k] <= '0;
      else if (load) bank[k] <= weights[4*k +: 4];
  end

  assign weight = bank[tap];
endmodule

// File: rtl/kernel_accumulator.sv
// Sequential MAC over one KernelDim x KernelDim window; one sum per window on o_valid/i_ready.
// Define KERNEL_ACC_SATURATE_EN to saturate o_data instead of truncating it.
module kernel_accumulator
  import cnn_pkg::*;
#(
  parameter int BitSize       = 32,
  parameter int FixedPointPos = 0,
  parameter int KernelDim     = 3
)(
  input  logic                                 clk,
  input  logic                                 res_n,
  input  logic                                 i_weight_load,
  input  logic [4*KernelDim*KernelDim-1:0]     i_weights,
  kernel_accumulator_if.slave                  s
);
  localparam int N     = KernelDim * KernelDim;
  localparam int TapW  = (N > 1) ? $clog2(N) : 1;
  localparam int ProdW = BitSize + 4;
  localparam int AccW  = acc_width(BitSize, N);

  kacc_state_t               state, nxt;
  logic [TapW-1:0]           tap;
  logic signed [AccW-1:0]    acc, acc_nxt, prod_ext;
  logic signed [ProdW-1:0]   din_x, w_x, prod;
  logic [BitSize-1:0]        o_data_q, out_val;
  weight_t                   weight;
  logic                      accept, last;

  kernel_weight_bank #(.N(N), .TapW(TapW)) u_bank (
    .clk     (clk),
    .res_n   (res_n),
    .load    (i_weight_load && state == IDLE),
    .weights (i_weights),
    .tap     (tap),
    .weight  (weight)
  );

  assign s.o_ready = (state != OUT);
  assign s.o_valid = (state == OUT);
  assign s.o_data  = o_data_q;
  assign accept    = s.i_valid && s.o_ready;
  assign last      = (tap == TapW'(N - 1));

  // Operands widened first so the product is exact before the fixed-point shift.
  assign din_x    = ProdW'(s.i_data);
  assign w_x      = ProdW'(weight);
  assign prod     = (din_x * w_x) >>> FixedPointPos;
  assign prod_ext = AccW'(prod);
  assign acc_nxt  = (tap == '0) ? prod_ext : acc + prod_ext;

`ifdef KERNEL_ACC_SATURATE_EN
  assign out_val = BitSize'(sat_to_bits(64'(acc_nxt), BitSize));
`else
  assign out_val = acc_nxt[BitSize-1:0];
`endif

  always_ff @(posedge clk or negedge res_n)
    if (!res_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = last ? OUT : ACCUM;
      ACCUM:   if (accept && last) nxt = OUT;
      OUT:     if (s.i_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // o_data is latched on the closing tap so it stays put through OUT and the next window.
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      tap      <= '0;
      acc      <= '0;
      o_data_q <= '0;
    end else if (accept) begin
      tap <= last ? '0 : tap + 1'b1;
      acc <= acc_nxt;
      if (last) o_data_q <= out_val;
    end
endmodule

// File: tb/tb_kernel_accumulator.sv
// Directed bench: window-level model for the default DUT plus literal checks on
// fixed-point and narrow-width instances.
module tb_kernel_accumulator;
  localparam int N = 9;

  logic           clk = 1'b0;
  logic           res_n = 1'b0;
  logic           wl = 1'b0;
  logic [4*N-1:0] wts = '0;

  kernel_accumulator_if #(.BitSize(32)) ka ();
  kernel_accumulator_if #(.BitSize(32)) kf ();
  kernel_accumulator_if #(.BitSize(8))  kn ();

  always #5 clk = ~clk;

  kernel_accumulator #(.BitSize(32), .FixedPointPos(0), .KernelDim(3)) dut_a (
    .clk(clk), .res_n(res_n), .i_weight_load(wl), .i_weights(wts), .s(ka.slave));
  kernel_accumulator #(.BitSize(32), .FixedPointPos(2), .KernelDim(3)) dut_f (
    .clk(clk), .res_n(res_n), .i_weight_load(wl), .i_weights(wts), .s(kf.slave));
  kernel_accumulator #(.BitSize(8), .FixedPointPos(0), .KernelDim(3)) dut_n (
    .clk(clk), .res_n(res_n), .i_weight_load(wl), .i_weights(wts), .s(kn.slave));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Window-level model of dut_a: weights, running sum, tap count, pending result.
  int                 m_w [N];
  longint             m_sum;
  int                 m_cnt;
  bit                 m_ov;
  logic signed [31:0] m_od;

  initial forever begin
    @(negedge clk);
    if (!res_n) begin
      foreach (m_w[k]) m_w[k] = 0;
      m_sum = 0; m_cnt = 0; m_ov = 0; m_od = '0;
      chk("rst_valid", ka.o_valid, 0);
      chk("rst_data",  ka.o_data,  0);
    end else begin
      chk("o_valid", ka.o_valid, m_ov);
      chk("o_ready", ka.o_ready, !m_ov);
      chk("o_data",  ka.o_data,  m_od);
      if (m_ov) begin
        if (ka.i_ready) m_ov = 0;
      end else begin
        bit idle;
        idle = (m_cnt == 0);
        if (ka.i_valid) begin
          m_sum += longint'(ka.i_data) * m_w[m_cnt];
          m_cnt++;
          if (m_cnt == N) begin
            m_ov = 1; m_od = 32'(m_sum); m_sum = 0; m_cnt = 0;
          end
        end
        if (idle && wl) begin
          for (int k = 0; k < N; k++) begin
            logic signed [3:0] nib;
            nib = wts[4*k +: 4];
            m_w[k] = nib;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_w(input logic [3:0] w);
    wts = {N{w}}; wl = 1'b1; tick(); wl = 1'b0;
  endtask

  task automatic send_a(input int base, input int step, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin ka.i_valid = 1'b0; tick(); end
      ka.i_valid = 1'b1; ka.i_data = base + step * k; tick();
    end
    ka.i_valid = 1'b0;
  endtask

  task automatic drain_a();
    ka.i_ready = 1'b1; tick(); ka.i_ready = 1'b0;
    chk("drain_valid", ka.o_valid, 0);
  endtask

  initial begin
    ka.i_valid = 0; ka.i_data = 0; ka.i_ready = 0;
    kf.i_valid = 0; kf.i_data = 0; kf.i_ready = 0;
    kn.i_valid = 0; kn.i_data = 0; kn.i_ready = 0;
    repeat (3) tick();
    chk("rst_ready_lit", ka.o_ready, 1);
    chk("rst_data_lit",  ka.o_data,  0);
    res_n = 1'b1; tick();

    // weights +1, inputs 1..9
    load_w(4'h1); send_a(1, 1, N, 0);
    chk("sum45_valid", ka.o_valid, 1);
    chk("sum45", ka.o_data, 45);
    drain_a();

    // weights -1, inputs 1..9
    load_w(4'hF); send_a(1, 1, N, 0);
    chk("sum_neg45", ka.o_data, 32'shFFFFFFD3);
    drain_a();

    // load together with the first accept: tap 0 still sees -1, rest see +2
    wts = {N{4'h2}}; wl = 1'b1; ka.i_valid = 1'b1; ka.i_data = 10; tick();
    wl = 1'b0; send_a(1, 1, N - 1, 1);
    chk("load_same_cycle", ka.o_data, 62);
    drain_a();

    // backpressure: extra valid and a weight load in OUT are both ignored
    send_a(3, 0, N, 0);
    for (int c = 0; c < 5; c++) begin
      ka.i_valid = 1'b1; ka.i_data = 100; wts = {N{4'h7}}; wl = 1'b1; tick();
      chk("bp_valid", ka.o_valid, 1);
      chk("bp_ready", ka.o_ready, 0);
      chk("bp_data",  ka.o_data,  54);
    end
    ka.i_valid = 1'b0; wl = 1'b0;
    drain_a();
    send_a(1, 0, N, 0);
    chk("fresh_after_bp", ka.o_data, 18);
    drain_a();

    // reset mid-window: sum dropped and weights cleared
    send_a(5, 0, 4, 0);
    res_n = 1'b0; tick(); res_n = 1'b1; tick();
    send_a(1, 0, N, 0);
    chk("zero_weights", ka.o_data, 0);
    chk("zero_weights_valid", ka.o_valid, 1);
    drain_a();
    load_w(4'h1); send_a(1, 0, N, 0);
    chk("after_reset_sum9", ka.o_data, 9);
    drain_a();

    // FixedPointPos=2, weights 4, inputs 8 with gaps
    load_w(4'h4);
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(1, 2)) begin kf.i_valid = 1'b0; tick(); end
      kf.i_valid = 1'b1; kf.i_data = 8; tick();
    end
    kf.i_valid = 1'b0;
    chk("fp2_valid", kf.o_valid, 1);
    chk("fp2_sum72", kf.o_data, 72);
    kf.i_ready = 1'b1; tick(); kf.i_ready = 1'b0;
    chk("fp2_drain", kf.o_valid, 0);

    // BitSize=8 overflow: exact sum 8001
    load_w(4'h7);
    for (int k = 0; k < N; k++) begin
      kn.i_valid = 1'b1; kn.i_data = 8'sd127; tick();
    end
    kn.i_valid = 1'b0;
    chk("narrow_valid", kn.o_valid, 1);
`ifdef KERNEL_ACC_SATURATE_EN
    chk("narrow_sat", kn.o_data, 8'sh7F);
`else
    chk("narrow_wrap", kn.o_data, 8'sh41);
`endif
    kn.i_ready = 1'b1; tick(); kn.i_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/kernel_accumulator.md
Name: kernel_accumulator

Overview:
- Sequential multiply-accumulate stage for one convolution window.
- Accepts a stream of BitSize-bit signed activations, one per tap.
- Multiplies each by its 4-bit signed kernel weight and accumulates KernelDim*KernelDim taps.
- Emits one BitSize-bit window sum over a valid/ready handshake to the next layer stage (activation/pooling).

Parameters:
- BitSize, 32, activation and output width (signed).
- FixedPointPos, 0, arithmetic right-shift applied to each product (weight fractional bits).
- KernelDim, 3, kernel edge; N = KernelDim*KernelDim taps.

Ports:
- clk  in  1  clock, rising edge.
- res_n  in  1  asynchronous active-low reset.
- i_weight_load  in  1  load kernel weights (IDLE only).
- i_weights  in  4*N  packed signed 4-bit weights; tap k = bits [4k+3:4k].
- i_valid  in  1  activation valid.
- i_data  in  BitSize  signed activation.
- o_ready  out  1  stage can accept an activation.
- o_valid  out  1  window sum valid.
- o_data  out  BitSize  signed window sum.
- i_ready  in  1  downstream accepts o_data.

Behaviour:
- Reset (async, res_n=0): state=IDLE, tap=0, acc=0, all weights=0, o_valid=0, o_data=0. o_ready=1 on the first cycle after release.
- States and transitions:
  - IDLE: the first accept (i_valid & o_ready) goes to ACCUM, or to OUT if N=1.
  - ACCUM: the accept at tap=N-1 goes to OUT.
  - OUT: o_valid & i_ready goes to IDLE.
- o_ready = 1 in IDLE and ACCUM, 0 in OUT. Registered state, combinational decode.
- Per accept: prod = (i_data * weight[tap]) >>> FixedPointPos.
  - Exact signed width BitSize+4.
  - Sign-extended to AccW = BitSize+4+clog2(N).
- Accumulation:
  - tap 0: acc <= prod (implicit clear).
  - other taps: acc <= acc + prod.
  - tap increments per accept and wraps to 0 after N-1.
- Latency: o_valid rises the cycle after the Nth accept. o_data = acc[BitSize-1:0] (wrapping truncation).
- OUT holds o_valid and o_data stable until i_ready. Entering IDLE after the handshake clears o_valid; o_data holds its last value.
- i_valid gaps in ACCUM: no state change, acc and tap hold.
- i_weight_load:
  - Captured only in IDLE, at the next edge.
  - Ignored in ACCUM and OUT.
  - Load and accept in the same IDLE cycle: that accept uses the OLD weights; new weights apply from the next accept.
- Reset mid-ACCUM or mid-OUT: partial sum discarded, weights zeroed. Software must reload the weights.

Optional Feature:
- Macro KERNEL_ACC_SATURATE_EN.
- Defined: o_data saturates acc to [-2^(BitSize-1), 2^(BitSize-1)-1].
- Undefined: plain truncation of acc to BitSize bits.
- The internal acc is full-precision in both cases.

Decomposition:
- Shared package cnn_pkg holds:
  - kacc_state_t enum {IDLE, ACCUM, OUT}.
  - weight_t (logic signed [3:0]).
  - function acc_width(BitSize, N).
  - function sat_to_bits, used only under the macro.
- One natural sub-module: kernel_weight_bank. It stores the N weights, has load-enable and async res_n, and is indexed by tap.

Test Plan:
- KernelDim=3, FixedPointPos=0, all weights 4'h1, inputs 1..9 back-to-back. Expect o_valid one cycle after the 9th accept, o_data=45.
- All weights 4'hF (-1), inputs 1..9. Expect o_data=32'hFFFFFFD3 (-45).
- FixedPointPos=2, weights 4'h4, inputs 8 on all taps with random i_valid gaps. Expect o_data=72, and tap/acc hold during the gaps.
- Backpressure: hold i_ready=0 for 5 cycles in OUT. Expect o_data stable, o_ready=0, extra i_valid ignored. After the i_ready handshake, the next window starts fresh.
- Reset pulse after 4 accepts, reload weights 1, inputs all 1. Expect o_data=9, with no residue from before the reset.
- BitSize=8, weights 4'h7, inputs 127 on all taps (exact sum 8001). Expect o_data=8'h41 (65) without KERNEL_ACC_SATURATE_EN and 8'h7F (127) with it.
